// File: rtl/seq_mult_32_if.sv
// seq_mult_32_if: start/busy/done handshake and operand/result bus of the
// sequential multiplier.
//   start   - request; the multiplier samples it in IDLE or DONE
//   a, b    - unsigned operands, sampled together with start
//   busy    - high while the multiplier is iterating
//   done    - one-cycle pulse when product becomes valid
//   product - 2*WIDTH-bit result, held until the next result is produced
// Modports: master = operand-issue side, slave = multiplier.
interface seq_mult_32_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_32.sv
// seq_mult_32: multi-cycle unsigned shift-and-add multiplier.
// One multiplier bit is retired per clock. Each iteration does one
// 2*WIDTH-bit add of the accumulator and the shifted multiplicand.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_mult_32_if.slave (start, a, b, busy, done, product)
// Optional feature (define SEQ_MULT_EARLY_EXIT_EN): finish as soon as the
// remaining multiplier bits are all zero. Products are the same either
// way; only the latency changes.
module seq_mult_32 #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_32_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mult;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_q;

  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mult_shr;
  logic                 last;

  // NOTE: every signal gets a value before any condition, so no latch is
  // inferred from this combinational block.
  always_comb begin
    acc_sum  = acc;
    mult_shr = mult >> 1;
    last     = (cnt == CW'(WIDTH - 1));
    // Carry out of the top bit is dropped. It cannot occur, because
    // a*b < 2^(2*WIDTH).
    if (mult[0]) acc_sum = acc + mcand;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // After this shift no 1 bits remain, so acc_sum is already the final product.
    if (mult_shr == '0) last = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // read the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mult      <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand <= {{WIDTH{1'b0}}, bus.a};
            mult  <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start is ignored here; the operands stay as they were loaded.
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mult  <= mult_shr;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            product_q <= acc_sum;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;

endmodule
